// File: rtl/fir_param.sv
// fir_param: N-tap, NB-bit signed direct-form FIR with serially loaded
// coefficients and a valid-qualified, one-cycle-latency output stage.
// Optional macro FIR_SAT_EN: clamp the output on overflow instead of wrapping.
module fir_param #(
    parameter int NB    = 16,
    parameter int NTAPS = 8
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic [NB-1:0] DIN,
    input  logic          VIN,
    input  logic [NB-1:0] H_DATA,
    input  logic          H_LOAD,
    output logic [NB-1:0] DOUT,
    output logic          VOUT,
    output logic          H_DONE
);
    localparam int GUARD = $clog2(NTAPS);
    localparam int ACC_W = 2*NB + GUARD;
    localparam int IDX_W = (NTAPS > 1) ? $clog2(NTAPS) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NTAPS-1);

    // dly[j] holds x[n-1-j]
    logic [NB-1:0]          dly  [0:NTAPS-2];
    logic [NB-1:0]          h    [0:NTAPS-1];
    logic [NB-1:0]          taps [0:NTAPS-1];
    logic signed [2*NB-1:0] prod [0:NTAPS-1];
    logic [ACC_W-1:0]       acc;
    logic [NB-1:0]          result;
    logic [IDX_W-1:0]       idx;

    // Tap vector: current sample followed by the delay line.
    always_comb begin
        taps[0] = DIN;
        for (int k = 1; k < NTAPS; k++) begin
            taps[k] = dly[k-1];
        end
    end

    // Full-precision signed products, operands sign-extended to 2*NB bits.
    always_comb begin
        for (int k = 0; k < NTAPS; k++) begin
            prod[k] = $signed({{NB{h[k][NB-1]}}, h[k]}) *
                      $signed({{NB{taps[k][NB-1]}}, taps[k]});
        end
    end

    // Accumulate with log2(NTAPS) guard bits so the sum itself never wraps.
    always_comb begin
        acc = '0;
        for (int k = 0; k < NTAPS; k++) begin
            acc = acc + {{GUARD{prod[k][2*NB-1]}}, prod[k]};
        end
    end

    // Drop the redundant sign bit and the low NB-1 fraction bits (floor).
    always_comb begin
        result = acc[2*NB-2:NB-1];
`ifdef FIR_SAT_EN
        if (acc[ACC_W-1:2*NB-2] != {(GUARD+2){acc[ACC_W-1]}}) begin
            result = acc[ACC_W-1] ? {1'b1, {(NB-1){1'b0}}} : {1'b0, {(NB-1){1'b1}}};
        end
`endif
    end

    // Output register and delay line advance only on valid samples.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int j = 0; j < NTAPS-1; j++) begin
                dly[j] <= '0;
            end
            DOUT <= '0;
            VOUT <= 1'b0;
        end else begin
            VOUT <= VIN;
            if (VIN) begin
                DOUT   <= result;
                dly[0] <= DIN;
                for (int j = 1; j < NTAPS-1; j++) begin
                    dly[j] <= dly[j-1];
                end
            end
        end
    end

    // Serial coefficient loader; first write lands in h[0] (newest-sample tap).
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int k = 0; k < NTAPS; k++) begin
                h[k] <= '0;
            end
            idx    <= '0;
            H_DONE <= 1'b0;
        end else if (H_LOAD) begin
            h[idx] <= H_DATA;
            if (H_DONE && (idx == '0)) begin
                H_DONE <= 1'b0;
            end
            if (idx == IDX_LAST) begin
                idx    <= '0;
                H_DONE <= 1'b1;
            end else begin
                idx <= idx + IDX_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_fir_param.sv
// Testbench for fir_param: directed steps plus randomized traffic checked
// against an arithmetic reference model of the filter.
module tb_fir_param;
    localparam int NB    = 16;
    localparam int NTAPS = 8;
    localparam longint MAXV = 2**(NB-1) - 1;
    localparam longint MINV = -(2**(NB-1));

    logic          CLK = 1'b0;
    logic          RST;
    logic [NB-1:0] DIN;
    logic          VIN;
    logic [NB-1:0] H_DATA;
    logic          H_LOAD;
    logic [NB-1:0] DOUT;
    logic          VOUT;
    logic          H_DONE;

    int checks = 0;
    int errors = 0;

    // Reference model state: m_hist[k] = x[n-k] for k >= 1
    longint        m_hist [NTAPS];
    longint        m_coef [NTAPS];
    int            m_idx;
    bit            m_done;
    logic [NB-1:0] m_dout;
    bit            m_vout;

    fir_param #(.NB(NB), .NTAPS(NTAPS)) dut (
        .CLK    (CLK),
        .RST    (RST),
        .DIN    (DIN),
        .VIN    (VIN),
        .H_DATA (H_DATA),
        .H_LOAD (H_LOAD),
        .DOUT   (DOUT),
        .VOUT   (VOUT),
        .H_DONE (H_DONE)
    );

    always #5 CLK = ~CLK;

    function automatic longint sx(input logic [NB-1:0] v);
        return longint'($signed(v));
    endfunction

    function automatic logic [NB-1:0] ref_result(input longint acc);
        longint q;
        logic [63:0] qb;
        q = acc >>> (NB-1);
`ifdef FIR_SAT_EN
        if (q > MAXV) q = MAXV;
        if (q < MINV) q = MINV;
`endif
        qb = q;
        return qb[NB-1:0];
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NTAPS; k++) begin
            m_hist[k] = 0;
            m_coef[k] = 0;
        end
        m_idx  = 0;
        m_done = 1'b0;
        m_dout = '0;
        m_vout = 1'b0;
    endtask

    task automatic model_step(input logic [NB-1:0] din, input logic vin,
                              input logic [NB-1:0] hdata, input logic hload);
        longint acc;
        if (vin) begin
            acc = m_coef[0] * sx(din);
            for (int k = 1; k < NTAPS; k++) acc += m_coef[k] * m_hist[k];
            m_dout = ref_result(acc);
            m_vout = 1'b1;
            for (int k = NTAPS-1; k > 1; k--) m_hist[k] = m_hist[k-1];
            m_hist[1] = sx(din);
        end else begin
            m_vout = 1'b0;
        end
        if (hload) begin
            if (m_done && m_idx == 0) m_done = 1'b0;
            m_coef[m_idx] = sx(hdata);
            if (m_idx == NTAPS-1) begin
                m_idx  = 0;
                m_done = 1'b1;
            end else begin
                m_idx++;
            end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at posedge+1; applies one cycle of inputs and checks the outputs.
    task automatic cycle(input logic [NB-1:0] din, input logic vin,
                         input logic [NB-1:0] hdata, input logic hload, input string tag);
        DIN    = din;
        VIN    = vin;
        H_DATA = hdata;
        H_LOAD = hload;
        model_step(din, vin, hdata, hload);
        @(posedge CLK);
        #1;
        check({tag, ".dout"},   32'(DOUT),   32'(m_dout));
        check({tag, ".vout"},   32'(VOUT),   32'(m_vout));
        check({tag, ".h_done"}, 32'(H_DONE), 32'(m_done));
    endtask

    task automatic pulse_reset();
        VIN    = 1'b0;
        H_LOAD = 1'b0;
        #2 RST = 1'b1;
        #2 RST = 1'b0;
        model_reset();
    endtask

    initial begin
        RST    = 1'b1;
        DIN    = '0;
        VIN    = 1'b0;
        H_DATA = '0;
        H_LOAD = 1'b0;
        model_reset();
        #12;
        check("reset.dout",   32'(DOUT),   32'h0);
        check("reset.vout",   32'(VOUT),   32'h0);
        check("reset.h_done", 32'(H_DONE), 32'h0);
        @(negedge CLK);
        RST = 1'b0;
        @(posedge CLK);
        #1;

        // Impulse response with ramped coefficients
        for (int k = 0; k < NTAPS; k++) cycle('0, 1'b0, 16'(16'h1000 * (k+1)), 1'b1, "load");
        cycle(16'h4000, 1'b1, '0, 1'b0, "impulse");
        check("impulse_first", 32'(DOUT), 32'h0800);
        cycle('0, 1'b1, '0, 1'b0, "impulse");
        check("impulse_second", 32'(DOUT), 32'h1000);
        for (int i = 0; i < NTAPS; i++) cycle('0, 1'b1, '0, 1'b0, "impulse");
        check("impulse_tail", 32'(DOUT), 32'h0);

        // Same impulse with three idle cycles between samples
        for (int i = 0; i < NTAPS+1; i++) begin
            cycle((i == 0) ? 16'h4000 : 16'h0000, 1'b1, '0, 1'b0, "gap_sample");
            for (int g = 0; g < 3; g++) cycle('0, 1'b0, '0, 1'b0, "gap_idle");
        end

        // Ninth write together with a valid sample: output uses old h[0]
        cycle(16'h4000, 1'b1, 16'h7FFF, 1'b1, "reload_vin");
        check("reload_old_coef", 32'(DOUT), 32'h0800);
        check("reload_done_drop", 32'(H_DONE), 32'h0);
        for (int i = 0; i < NTAPS; i++) cycle('0, 1'b1, '0, 1'b0, "flush");
        cycle(16'h4000, 1'b1, '0, 1'b0, "new_h0");
        check("reload_new_coef", 32'(DOUT), 32'h3FFF);

        // Randomized traffic with interleaved coefficient writes
        for (int i = 0; i < 80; i++) begin
            cycle(16'($urandom), ($urandom_range(0, 3) != 0), 16'($urandom),
                  ($urandom_range(0, 3) == 0), "random");
        end

        // Overflow: full-scale positive, then full-scale negative
        pulse_reset();
        for (int k = 0; k < NTAPS; k++) cycle('0, 1'b0, 16'h7FFF, 1'b1, "ovf_load");
        for (int i = 0; i < NTAPS; i++) cycle(16'h7FFF, 1'b1, '0, 1'b0, "ovf_pos");
`ifdef FIR_SAT_EN
        check("ovf_pos_8th", 32'(DOUT), 32'h7FFF);
`else
        check("ovf_pos_8th", 32'(DOUT), 32'hFFF0);
`endif
        for (int i = 0; i < NTAPS+2; i++) cycle(16'h8000, 1'b1, '0, 1'b0, "ovf_neg");

        // Asynchronous reset between edges in the middle of a stream
        pulse_reset();
        for (int k = 0; k < NTAPS; k++) cycle('0, 1'b0, 16'(16'h1000 * (k+1)), 1'b1, "mid_load");
        cycle(16'h4000, 1'b1, '0, 1'b0, "mid_stream");
        cycle('0, 1'b1, '0, 1'b0, "mid_stream");
        #2 RST = 1'b1;
        #1;
        check("async_rst.dout",   32'(DOUT),   32'h0);
        check("async_rst.vout",   32'(VOUT),   32'h0);
        check("async_rst.h_done", 32'(H_DONE), 32'h0);
        #2 RST = 1'b0;
        model_reset();
        for (int i = 0; i < 6; i++) cycle(16'($urandom), 1'b1, '0, 1'b0, "post_rst");
        check("post_rst_zero", 32'(DOUT), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
